// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared definitions for the instruction-fetch slice: the default datapath
// width, the ARM bubble encoding and the redirect-source enumeration with a
// small helper that resolves which redirect source wins in a given cycle.
package fetch_pkg;

  localparam int XLEN_DEFAULT = 32;

  // ADD R4, R4, #0 -- architecturally a no-op, used as the decode bubble.
  localparam logic [31:0] ARM_NOP_ADD_R4 = 32'hE284_4000;

  typedef enum logic [1:0] {
    RD_NONE,
    RD_BRANCH,
    RD_PCWRITE
  } redirect_src_e;

  // A branch resolved in decode/execute takes priority over a concurrent
  // write to R15 from the ALU.
  function automatic redirect_src_e pick_redirect(input logic br, input logic pcwr);
    if (br) begin
      return RD_BRANCH;
    end else if (pcwr) begin
      return RD_PCWRITE;
    end else begin
      return RD_NONE;
    end
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo
// Generic DEPTH x WIDTH synchronous FIFO with a single-cycle flush.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   flush               drop all entries; a same-cycle push or pop is ignored
//   push, push_data     write one entry (accepted when not full, or full with pop)
//   pop                 remove the head entry (ignored when empty)
//   head                current head entry (registered storage, no bypass)
//   count, full, empty  occupancy status
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      rd_ptr;
  logic [AW:0]      wr_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry an extra wrap bit so full and empty differ only in the MSB.
  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head    = mem[rd_ptr[AW-1:0]];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer update; flush collapses the queue by pulling the read pointer
  // onto the write pointer, which also cancels any same-cycle push or pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
    end
  end

  // Storage is not reset; entries are only visible once the pointers cover them.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue
// Instruction-fetch stage: owns the fetch PC, issues sequential word requests
// to instruction memory, buffers returned words with their PCs in a prefetch
// queue and presents them to decode over valid/ready. Branch and PC-write
// redirects flush the queue and discard responses still in flight.
// Ports:
//   clk, reset_n                   clock, asynchronous active-low reset
//   br_taken, br_target            branch redirect (wins over pcwr)
//   pcwr_valid, pcwr_target        execute-stage write to R15
//   imem_req, imem_addr, imem_gnt  request side of instruction memory
//   imem_rvalid, imem_rdata        in-order response side
//   dec_valid, dec_inst, dec_pc    instruction presented to decode
//   dec_ready                      decode consumes this cycle
//   dec_nop                        present NOP_INST instead of the queue head
// Optional build macro FETCH_PERF_EN adds perf_fetched, perf_starve and
// perf_flush 32-bit event counters.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] NOP_INST = XLEN'(ARM_NOP_ADD_R4)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            pcwr_valid,
  input  logic [XLEN-1:0] pcwr_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            dec_valid,
  output logic [XLEN-1:0] dec_inst,
  output logic [XLEN-1:0] dec_pc,
  input  logic            dec_ready,
  input  logic            dec_nop
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_starve,
  output logic [31:0]     perf_flush
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0]   fetch_pc;
  logic [XLEN-1:0]   resp_pc;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     discard;

  redirect_src_e     rd_src;
  logic              redirect;
  logic [XLEN-1:0]   redirect_pc;

  logic [2*XLEN-1:0] fifo_head;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic [XLEN-1:0]   head_inst;
  logic [XLEN-1:0]   head_pc;

  logic [CW:0]       in_use;
  logic              issue;
  logic              resp_accept;

  // Resolve the redirect source and its word-aligned target.
  always_comb begin
    rd_src      = pick_redirect(br_taken, pcwr_valid);
    redirect    = 1'b0;
    redirect_pc = '0;
    case (rd_src)
      RD_BRANCH: begin
        redirect    = 1'b1;
        redirect_pc = br_target & ~XLEN'(3);
      end
      RD_PCWRITE: begin
        redirect    = 1'b1;
        redirect_pc = pcwr_target & ~XLEN'(3);
      end
      default: begin
      end
    endcase
  end

  // Credit check: every issued request already owns a queue slot, so a
  // response can never arrive to a full queue.
  assign in_use      = {1'b0, fifo_count} + {1'b0, outstanding};
  assign imem_req    = reset_n && !redirect && (in_use < (CW+1)'(DEPTH));
  assign imem_addr   = fetch_pc;
  assign issue       = imem_req && imem_gnt;
  assign resp_accept = imem_rvalid && (discard == '0);
  assign fifo_pop    = dec_ready && !dec_nop && !fifo_empty;
  assign fifo_push   = resp_accept && (!fifo_full || fifo_pop);
  assign head_inst   = fifo_head[2*XLEN-1:XLEN];
  assign head_pc     = fifo_head[XLEN-1:0];

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2*XLEN)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (redirect),
    .push      (fifo_push),
    .push_data ({imem_rdata, resp_pc}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Fetch and response PCs advance independently; a redirect reloads both so
  // the first accepted response after the flush is tagged with the target.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      resp_pc  <= redirect_pc;
    end else begin
      if (issue) begin
        fetch_pc <= fetch_pc + XLEN'(4);
      end
      if (fifo_push) begin
        resp_pc <= resp_pc + XLEN'(4);
      end
    end
  end

  // In-flight bookkeeping. On a redirect every request still in flight after
  // this cycle's response belongs to the old path and must be dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding + CW'(issue) - CW'(imem_rvalid && (outstanding != '0));
      if (redirect) begin
        discard <= (outstanding != '0) ? (outstanding - CW'(imem_rvalid)) : '0;
      end else if (imem_rvalid && (discard != '0)) begin
        discard <= discard - 1'b1;
      end
    end
  end

  // Decode presentation. The bubble keeps the head's PC (or the fetch PC when
  // nothing is queued) and never pops; everything is forced to zero in reset.
  always_comb begin
    dec_valid = 1'b0;
    dec_inst  = '0;
    dec_pc    = '0;
    if (reset_n) begin
      if (dec_nop) begin
        dec_valid = 1'b1;
        dec_inst  = NOP_INST;
        dec_pc    = fifo_empty ? fetch_pc : head_pc;
      end else if (!fifo_empty) begin
        dec_valid = 1'b1;
        dec_inst  = head_inst;
        dec_pc    = head_pc;
      end
    end
  end

`ifdef FETCH_PERF_EN
  // Event counters; they wrap naturally at 2^32.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetched <= '0;
      perf_starve  <= '0;
      perf_flush   <= '0;
    end else begin
      if (fifo_push && !redirect) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (dec_ready && !dec_valid) begin
        perf_starve <= perf_starve + 32'd1;
      end
      if (redirect) begin
        perf_flush <= perf_flush + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue
// Self-checking bench for fetch_queue. A memory model returns each fetch
// address as its instruction word with configurable in-order latency, and a
// reference model tracks the next PC decode must see: it starts at the reset
// PC, restarts at the aligned redirect target, and advances by 4 per consumed
// instruction.
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'hE284_4000;

  logic        clk;
  logic        reset_n;
  logic        br_taken;
  logic [31:0] br_target;
  logic        pcwr_valid;
  logic [31:0] pcwr_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        dec_valid;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic        dec_ready;
  logic        dec_nop;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_starve;
  logic [31:0] perf_flush;
`endif

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          issued = 0;
  int          consumed = 0;
  int          base_inflight = 0;
  logic [31:0] exp_pc;
  bit          gnt_random = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  fetch_queue #(
    .XLEN     (32),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC),
    .NOP_INST (NOP)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .pcwr_valid  (pcwr_valid),
    .pcwr_target (pcwr_target),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .dec_valid   (dec_valid),
    .dec_inst    (dec_inst),
    .dec_pc      (dec_pc),
    .dec_ready   (dec_ready),
    .dec_nop     (dec_nop)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_starve  (perf_starve),
    .perf_flush   (perf_flush)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  // Instruction memory: handshakes are observed at the negedge before the edge
  // that completes them; responses come back in order, one per cycle, with
  // data equal to the requested address.
  task automatic mem_model();
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        pend_addr.delete();
        pend_due.delete();
      end else begin
        if (imem_rvalid && pend_addr.size() > 0) begin
          void'(pend_addr.pop_front());
          void'(pend_due.pop_front());
        end
        if (imem_req && imem_gnt) begin
          pend_addr.push_back(imem_addr);
          pend_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
          issued++;
        end
      end
      @(posedge clk);
      cyc++;
      #1;
      imem_gnt = gnt_random ? 1'($urandom_range(1, 0)) : 1'b1;
      if (reset_n && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = pend_addr[0];
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
      end
    end
  endtask

  // Reference model: decode must see a gapless +4 stream from the last
  // (aligned) redirect target, with instruction word equal to its PC.
  task automatic scoreboard();
    exp_pc = RESET_PC;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        exp_pc = RESET_PC;
      end else if (br_taken || pcwr_valid) begin
        exp_pc = (br_taken ? br_target : pcwr_target) & ~32'h3;
      end else if (dec_valid) begin
        checks++;
        if (dec_nop) begin
          if (dec_inst !== NOP) begin
            failures++;
            $display("[TB] FAIL nop_inst: got %h want %h", dec_inst, NOP);
          end
        end else begin
          if (dec_pc !== exp_pc || dec_inst !== exp_pc) begin
            failures++;
            $display("[TB] FAIL stream: pc=%h inst=%h want both %h", dec_pc, dec_inst, exp_pc);
          end
          if (dec_ready) begin
            exp_pc = exp_pc + 32'd4;
            consumed++;
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    dec_nop   = 1'b1;
    dec_ready = 1'b1;
    repeat (3) step();
    sample();
    checks++;
    if (imem_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_req: got %b want 0", imem_req); end
    checks++;
    if (dec_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b want 0", dec_valid); end
    checks++;
    if (dec_inst !== 32'h0) begin failures++; $display("[TB] FAIL reset_inst: got %h want 0", dec_inst); end
    checks++;
    if (dec_pc !== 32'h0) begin failures++; $display("[TB] FAIL reset_pc: got %h want 0", dec_pc); end
    step();
    reset_n = 1'b1;
    dec_nop = 1'b0;
    base_inflight = issued - consumed;
    sample();
    checks++;
    if (imem_req !== 1'b1) begin failures++; $display("[TB] FAIL first_req: got %b want 1", imem_req); end
    checks++;
    if (imem_addr !== RESET_PC) begin failures++; $display("[TB] FAIL first_addr: got %h want %h", imem_addr, RESET_PC); end
  endtask

  task automatic test_stream();
    int c0;
    repeat (4) step();
    sample();
    c0 = consumed;
    repeat (20) sample();
    checks++;
    if (consumed - c0 != 20) begin
      failures++;
      $display("[TB] FAIL throughput: got %0d instructions in 20 cycles want 20", consumed - c0);
    end
  endtask

  task automatic test_stall();
    logic [31:0] held;
    step();
    dec_ready = 1'b0;
    sample();
    held = exp_pc;
    repeat (9) sample();
    checks++;
    if (imem_req !== 1'b0) begin failures++; $display("[TB] FAIL stall_req: got %b want 0", imem_req); end
    checks++;
    if (issued - consumed - base_inflight != DEPTH) begin
      failures++;
      $display("[TB] FAIL stall_inflight: got %0d want %0d", issued - consumed - base_inflight, DEPTH);
    end
    checks++;
    if (dec_valid !== 1'b1 || dec_pc !== held) begin
      failures++;
      $display("[TB] FAIL stall_hold: valid=%b pc=%h want 1 %h", dec_valid, dec_pc, held);
    end
    step();
    dec_ready = 1'b1;
    repeat (10) step();
  endtask

  task automatic test_branch();
    int  n;
    bit  found;
    lat_min = 3;
    lat_max = 3;
    repeat (12) step();
    n = 0;
    do begin
      sample();
      n++;
    end while (pend_addr.size() != 3 && n < 50);
    checks++;
    if (pend_addr.size() != 3) begin
      failures++;
      $display("[TB] FAIL branch_setup: in flight %0d want 3", pend_addr.size());
    end
    step();
    br_taken  = 1'b1;
    br_target = 32'h0000_0100;
    sample();
    checks++;
    if (imem_req !== 1'b0) begin failures++; $display("[TB] FAIL redirect_req: got %b want 0", imem_req); end
    step();
    br_taken = 1'b0;
    sample();
    checks++;
    if (imem_addr !== 32'h100) begin failures++; $display("[TB] FAIL branch_addr: got %h want 100", imem_addr); end
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (dec_valid && !dec_nop) found = 1;
      else sample();
    end
    checks++;
    if (!found || dec_pc !== 32'h100 || dec_inst !== 32'h100) begin
      failures++;
      $display("[TB] FAIL branch_target: found=%0d pc=%h inst=%h want 100", found, dec_pc, dec_inst);
    end
  endtask

  task automatic test_both();
    bit found;
    lat_min = 1;
    lat_max = 1;
    repeat (4) step();
    br_taken    = 1'b1;
    br_target   = 32'h0000_0200;
    pcwr_valid  = 1'b1;
    pcwr_target = 32'h0000_0300;
    step();
    br_taken   = 1'b0;
    pcwr_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      sample();
      if (dec_valid && !dec_nop) found = 1;
    end
    checks++;
    if (!found || dec_pc !== 32'h200) begin
      failures++;
      $display("[TB] FAIL both_priority: found=%0d pc=%h want 200", found, dec_pc);
    end
    repeat (4) step();
    pcwr_valid  = 1'b1;
    pcwr_target = 32'h0000_0303;
    step();
    pcwr_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      sample();
      if (dec_valid && !dec_nop) found = 1;
    end
    checks++;
    if (!found || dec_pc !== 32'h300) begin
      failures++;
      $display("[TB] FAIL pcwr_align: found=%0d pc=%h want 300", found, dec_pc);
    end
  endtask

  task automatic test_nop();
    logic [31:0] head;
    step();
    dec_ready = 1'b0;
    repeat (6) step();
    sample();
    head = exp_pc;
    step();
    dec_nop   = 1'b1;
    dec_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sample();
      checks++;
      if (dec_valid !== 1'b1 || dec_inst !== NOP) begin
        failures++;
        $display("[TB] FAIL nop_present: valid=%b inst=%h want 1 %h", dec_valid, dec_inst, NOP);
      end
      checks++;
      if (dec_pc !== head) begin failures++; $display("[TB] FAIL nop_pc: got %h want %h", dec_pc, head); end
      step();
    end
    dec_nop   = 1'b0;
    dec_ready = 1'b0;
    sample();
    checks++;
    if (dec_inst !== head || dec_pc !== head) begin
      failures++;
      $display("[TB] FAIL nop_resume: inst=%h pc=%h want %h", dec_inst, dec_pc, head);
    end
    step();
    dec_ready = 1'b1;
    repeat (6) step();
  endtask

  task automatic test_mid_reset();
    repeat (6) step();
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || dec_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midreset_ctrl: req=%b valid=%b want 0 0", imem_req, dec_valid);
    end
    checks++;
    if (dec_inst !== 32'h0 || dec_pc !== 32'h0) begin
      failures++;
      $display("[TB] FAIL midreset_data: inst=%h pc=%h want 0 0", dec_inst, dec_pc);
    end
    step();
    reset_n = 1'b1;
    sample();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      failures++;
      $display("[TB] FAIL midreset_restart: req=%b addr=%h want 1 %h", imem_req, imem_addr, RESET_PC);
    end
    repeat (10) step();
  endtask

  task automatic test_random();
    int c0;
    gnt_random = 1;
    lat_min    = 1;
    lat_max    = 3;
    for (int i = 0; i < 400; i++) begin
      step();
      dec_ready  = ($urandom_range(3, 0) != 0);
      dec_nop    = ($urandom_range(7, 0) == 0);
      br_taken   = 1'b0;
      pcwr_valid = 1'b0;
      if ($urandom_range(15, 0) == 0) begin
        br_taken    = 1'($urandom_range(1, 0));
        pcwr_valid  = !br_taken || 1'($urandom_range(1, 0));
        br_target   = $urandom & 32'h0003_FFFF;
        pcwr_target = $urandom & 32'h0003_FFFF;
      end
    end
    step();
    br_taken   = 1'b0;
    pcwr_valid = 1'b0;
    dec_nop    = 1'b0;
    dec_ready  = 1'b1;
    gnt_random = 0;
    lat_max    = 1;
    sample();
    c0 = consumed;
    repeat (20) sample();
    checks++;
    if (consumed - c0 < 15) begin
      failures++;
      $display("[TB] FAIL random_drain: got %0d instructions in 20 cycles want at least 15", consumed - c0);
    end
  endtask

  // Scenarios run in sequence; the memory model and scoreboard run alongside.
  initial begin
    reset_n     = 1'b0;
    br_taken    = 1'b0;
    br_target   = '0;
    pcwr_valid  = 1'b0;
    pcwr_target = '0;
    dec_ready   = 1'b0;
    dec_nop     = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    fork
      mem_model();
      scoreboard();
    join_none
    $display("[TB] starting fetch_queue bench");
    test_reset();
    test_stream();
    test_stall();
    test_branch();
    test_both();
    test_nop();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
